neighbor_link_ctx: RTL and testbench

- Multi-context successor to the single-context internal neighbor link, for the Helios decoding-graph array.
- Stores weight, boundary condition, erasure flag, growth and error flag for NUM_CONTEXTS independent slots, so one physical link serves several time-multiplexed decoding blocks.
- Adds variable per-cycle growth steps, a counted parameter-load handshake and registered context switching.
- Sits between two processing units (A and B), exactly where the single-context link sits today.

---
 rtl/neighbor_link_ctx_pkg.sv | 42 ++++
 rtl/link_ctx_slot.sv | 97 +++++++++
 rtl/neighbor_link_ctx.sv | 117 +++++++++++
 tb/tb_neighbor_link_ctx.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/neighbor_link_ctx_pkg.sv
// Shared types and constants for the multi-context neighbor link.
// Stage encodings match the Helios controller.
package neighbor_link_ctx_pkg;

  localparam int STAGE_WIDTH = 3;

  localparam logic [STAGE_WIDTH-1:0] STAGE_IDLE                = 3'd0;
  localparam logic [STAGE_WIDTH-1:0] STAGE_PARAMETERS_LOADING  = 3'd1;
  localparam logic [STAGE_WIDTH-1:0] STAGE_MEASUREMENT_LOADING = 3'd2;
  localparam logic [STAGE_WIDTH-1:0] STAGE_GROW                = 3'd3;
  localparam logic [STAGE_WIDTH-1:0] STAGE_MERGE               = 3'd4;
  localparam logic [STAGE_WIDTH-1:0] STAGE_PEELING             = 3'd5;
  localparam logic [STAGE_WIDTH-1:0] STAGE_RESULT_VALID        = 3'd6;
  localparam logic [STAGE_WIDTH-1:0] STAGE_ERASURE_LOADING     = 3'd7;

  localparam logic [1:0] BC_NORMAL   = 2'd0;
  localparam logic [1:0] BC_BOUNDARY = 2'd1;
  localparam logic [1:0] BC_NONE     = 2'd2;

  localparam int DEF_ADDRESS_WIDTH = 6;
  localparam int DEF_MAX_WEIGHT    = 2;
  localparam int DEF_NUM_CONTEXTS  = 4;
  localparam int DEF_STEP_WIDTH    = 2;

  localparam int CTX_LBW = $clog2(DEF_MAX_WEIGHT + 1);
  localparam int GROW_WIDTH =
    $clog2(DEF_MAX_WEIGHT + 2 * ((1 << DEF_STEP_WIDTH) - 1) + 1);

  typedef struct packed {
    logic [CTX_LBW-1:0] weight;
    logic [1:0]         bc;
    logic               erased;
    logic [CTX_LBW-1:0] growth;
    logic               is_error;
  } link_ctx_t;

  // Codes 2 and 3 both mean the edge does not exist.
  function automatic logic bc_is_none(input logic [1:0] bc);
    return bc[1];
  endfunction

endpackage

// File: rtl/link_ctx_slot.sv
// One context slot of the neighbor link: parameter storage plus
// the growth and error update, gated by upd_en.
module link_ctx_slot
  import neighbor_link_ctx_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic [STAGE_WIDTH-1:0]    stage,
  input  logic                      load_en,
  input  logic [CTX_LBW-1:0]        load_weight,
  input  logic [1:0]                load_bc,
  input  logic                      erase_en,
  input  logic                      erase_val,
  input  logic                      upd_en,
  input  logic [DEF_STEP_WIDTH-1:0] a_increase,
  input  logic [DEF_STEP_WIDTH-1:0] b_increase,
  input  logic                      a_is_error_in,
  input  logic                      b_is_error_in,
  input  logic                      is_error_systolic_in,
  output link_ctx_t                 ctx
);

  logic [GROW_WIDTH-1:0] step;
  logic [GROW_WIDTH-1:0] sum;
  logic [CTX_LBW-1:0]    grown;
  logic                  peel_err;
  logic [CTX_LBW-1:0]    growth_next;
  logic                  err_next;

  // Sum is wide enough for the largest growth plus both steps.
  always_comb begin
    step = GROW_WIDTH'(a_increase);
    if (ctx.bc == BC_NORMAL)
      step = step + GROW_WIDTH'(b_increase);
    sum = GROW_WIDTH'(ctx.growth) + step;
    if (bc_is_none(ctx.bc))
      grown = '0;
    else if (ctx.erased)
      grown = ctx.weight;
    else if (sum > GROW_WIDTH'(ctx.weight))
      grown = ctx.weight;
    else
      grown = sum[CTX_LBW-1:0];
  end

  always_comb begin
    if (bc_is_none(ctx.bc))
      peel_err = 1'b0;
    else if (ctx.bc == BC_BOUNDARY)
      peel_err = a_is_error_in;
    else
      peel_err = a_is_error_in | b_is_error_in;
  end

  always_comb begin
    growth_next = ctx.growth;
    err_next    = ctx.is_error;
    unique case (1'b1)
      stage == STAGE_MEASUREMENT_LOADING: begin
        growth_next = '0;
        err_next    = 1'b0;
      end
      stage == STAGE_ERASURE_LOADING: begin
        err_next = 1'b0;
      end
      stage == STAGE_PARAMETERS_LOADING: begin
        err_next = peel_err;
      end
      stage == STAGE_RESULT_VALID: begin
        growth_next = grown;
        err_next    = is_error_systolic_in;
      end
      default: begin
        growth_next = grown;
        err_next    = peel_err;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctx <= '0;
    end else begin
      if (load_en) begin
        ctx.weight <= load_weight;
        ctx.bc     <= load_bc;
      end
      if (erase_en)
        ctx.erased <= erase_val;
      if (upd_en) begin
        ctx.growth   <= growth_next;
        ctx.is_error <= err_next;
      end
    end
  end

endmodule

// File: rtl/neighbor_link_ctx.sv
// Multi-context neighbor link between processing units A and B.
// Holds one slot per context; outputs read the active slot.
module neighbor_link_ctx
  import neighbor_link_ctx_pkg::*;
#(
  parameter  int ADDRESS_WIDTH     = DEF_ADDRESS_WIDTH,
  parameter  int MAX_WEIGHT        = DEF_MAX_WEIGHT,
  parameter  int NUM_CONTEXTS      = DEF_NUM_CONTEXTS,
  parameter  int STEP_WIDTH        = DEF_STEP_WIDTH,
  localparam int LINK_BIT_WIDTH    = $clog2(MAX_WEIGHT + 1),
  localparam int CTX_WIDTH         = $clog2(NUM_CONTEXTS),
  localparam int EXPOSED_DATA_SIZE = ADDRESS_WIDTH + 7
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [STAGE_WIDTH-1:0]       global_stage,
  input  logic                         context_switch,
  input  logic [CTX_WIDTH-1:0]         context_sel,
  output logic [CTX_WIDTH-1:0]         active_ctx,
  input  logic                         param_valid,
  input  logic [LINK_BIT_WIDTH-1:0]    weight_in,
  input  logic [1:0]                   boundary_condition_in,
  output logic                         param_done,
  input  logic                         erased_valid,
  input  logic                         erased_in,
  input  logic [STEP_WIDTH-1:0]        a_increase,
  input  logic [STEP_WIDTH-1:0]        b_increase,
  output logic                         fully_grown,
  output logic                         is_boundary,
  input  logic [EXPOSED_DATA_SIZE-1:0] a_input_data,
  input  logic [EXPOSED_DATA_SIZE-1:0] b_input_data,
  output logic [EXPOSED_DATA_SIZE-1:0] a_output_data,
  output logic [EXPOSED_DATA_SIZE-1:0] b_output_data,
  input  logic                         a_is_error_in,
  input  logic                         b_is_error_in,
  input  logic                         is_error_systolic_in,
  output logic                         is_error,
  output logic [LINK_BIT_WIDTH-1:0]    weight_out,
  output logic [1:0]                   boundary_condition_out,
  output logic                         erased_out
);

  localparam logic [CTX_WIDTH-1:0] LAST_CTX = CTX_WIDTH'(NUM_CONTEXTS - 1);

  logic [STAGE_WIDTH-1:0] prev_stage;
  logic [CTX_WIDTH-1:0]   load_ptr;
  logic [CTX_WIDTH-1:0]   eff_ptr;
  logic                   entering;
  logic                   param_wr;
  logic                   erase_wr;
  link_ctx_t              slots [NUM_CONTEXTS];
  link_ctx_t              cur;

  assign entering = (global_stage == STAGE_PARAMETERS_LOADING) &&
                    (prev_stage != STAGE_PARAMETERS_LOADING);
  // A write in the entry cycle already lands in slot 0.
  assign eff_ptr  = entering ? '0 : load_ptr;
  assign param_wr = param_valid &&
                    (global_stage == STAGE_PARAMETERS_LOADING);
  assign erase_wr = erased_valid &&
                    (global_stage == STAGE_ERASURE_LOADING);

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_stage <= STAGE_IDLE;
      load_ptr   <= '0;
      param_done <= 1'b0;
      active_ctx <= '0;
    end else begin
      prev_stage <= global_stage;
      if (context_switch)
        active_ctx <= context_sel;
      if (param_wr)
        load_ptr <= eff_ptr + CTX_WIDTH'(1);
      else if (entering)
        load_ptr <= '0;
      if (entering)
        param_done <= param_wr && (eff_ptr == LAST_CTX);
      else if (param_wr && (eff_ptr == LAST_CTX))
        param_done <= 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_CONTEXTS; i++) begin : g_slot
    link_ctx_slot u_slot (
      .clk                  (clk),
      .reset                (reset),
      .stage                (global_stage),
      .load_en              (param_wr && (eff_ptr == CTX_WIDTH'(i))),
      .load_weight          (weight_in),
      .load_bc              (boundary_condition_in),
      .erase_en             (erase_wr && (context_sel == CTX_WIDTH'(i))),
      .erase_val            (erased_in),
      .upd_en               (!context_switch &&
                             (active_ctx == CTX_WIDTH'(i))),
      .a_increase           (a_increase),
      .b_increase           (b_increase),
      .a_is_error_in        (a_is_error_in),
      .b_is_error_in        (b_is_error_in),
      .is_error_systolic_in (is_error_systolic_in),
      .ctx                  (slots[i])
    );
  end

  assign cur = slots[active_ctx];

  assign weight_out             = cur.weight;
  assign boundary_condition_out = cur.bc;
  assign erased_out             = cur.erased;
  assign is_error               = cur.is_error;
  assign fully_grown            = cur.growth >= cur.weight;
  assign is_boundary            = (cur.bc == BC_BOUNDARY) && fully_grown;

  assign a_output_data = (cur.bc == BC_NORMAL) ? b_input_data : '0;
  assign b_output_data = (cur.bc == BC_NORMAL) ? a_input_data : '0;

endmodule

// File: tb/tb_neighbor_link_ctx.sv
// Scoreboard bench for neighbor_link_ctx: expectations are queued
// with each stimulus cycle and compared after the clock edge.
module tb_neighbor_link_ctx;
  import neighbor_link_ctx_pkg::*;

  localparam int AW = 6;
  localparam int DW = AW + 7;

  logic            clk = 1'b0;
  logic            reset;
  logic [2:0]      stage;
  logic            cs;
  logic [1:0]      csel;
  logic [1:0]      act;
  logic            pv;
  logic [1:0]      w;
  logic [1:0]      bc;
  logic            pd;
  logic            ev;
  logic            ein;
  logic [1:0]      ai;
  logic [1:0]      bi;
  logic            fg;
  logic            ib;
  logic [DW-1:0]   ad;
  logic [DW-1:0]   bd;
  logic [DW-1:0]   aout;
  logic [DW-1:0]   bout;
  logic            ae;
  logic            be;
  logic            sys;
  logic            err;
  logic [1:0]      wout;
  logic [1:0]      bcout;
  logic            erout;

  neighbor_link_ctx dut (
    .clk                    (clk),
    .reset                  (reset),
    .global_stage           (stage),
    .context_switch         (cs),
    .context_sel            (csel),
    .active_ctx             (act),
    .param_valid            (pv),
    .weight_in              (w),
    .boundary_condition_in  (bc),
    .param_done             (pd),
    .erased_valid           (ev),
    .erased_in              (ein),
    .a_increase             (ai),
    .b_increase             (bi),
    .fully_grown            (fg),
    .is_boundary            (ib),
    .a_input_data           (ad),
    .b_input_data           (bd),
    .a_output_data          (aout),
    .b_output_data          (bout),
    .a_is_error_in          (ae),
    .b_is_error_in          (be),
    .is_error_systolic_in   (sys),
    .is_error               (err),
    .weight_out             (wout),
    .boundary_condition_out (bcout),
    .erased_out             (erout)
  );

  always #5 clk = ~clk;

  typedef enum int {
    S_ACT, S_PD, S_FG, S_IB, S_ERR, S_W, S_BC, S_ER, S_AOUT, S_BOUT
  } sel_e;

  typedef struct {
    string       tag;
    sel_e        sel;
    logic [31:0] exp;
  } item_t;

  item_t sbq[$];
  int    n_chk  = 0;
  int    n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    else
      n_pass++;
  endtask

  function automatic logic [31:0] obs(input sel_e s);
    case (s)
      S_ACT:  return 32'(act);
      S_PD:   return 32'(pd);
      S_FG:   return 32'(fg);
      S_IB:   return 32'(ib);
      S_ERR:  return 32'(err);
      S_W:    return 32'(wout);
      S_BC:   return 32'(bcout);
      S_ER:   return 32'(erout);
      S_AOUT: return 32'(aout);
      default: return 32'(bout);
    endcase
  endfunction

  task automatic expect_(input string tag, input sel_e s,
                         input logic [31:0] e);
    item_t it;
    it.tag = tag;
    it.sel = s;
    it.exp = e;
    sbq.push_back(it);
  endtask

  // Clock the pending stimulus in, then drain the scoreboard.
  task automatic step();
    item_t it;
    @(posedge clk);
    #1;
    while (sbq.size() > 0) begin
      it = sbq.pop_front();
      chk(it.tag, obs(it.sel), it.exp);
    end
  endtask

  task automatic load(input logic [1:0] wv, input logic [1:0] bv);
    pv = 1'b1;
    w  = wv;
    bc = bv;
  endtask

  initial begin
    reset = 1'b1; stage = STAGE_IDLE; cs = 0; csel = 0;
    pv = 0; w = 0; bc = 0; ev = 0; ein = 0; ai = 0; bi = 0;
    ad = 13'h0abc; bd = 13'h1234; ae = 0; be = 0; sys = 0;
    step();
    expect_("rst_act", S_ACT, 0);
    expect_("rst_pd", S_PD, 0);
    expect_("rst_fg", S_FG, 1);
    expect_("rst_w", S_W, 0);
    expect_("rst_err", S_ERR, 0);
    step();
    reset = 1'b0;

    // Load weights 2,1,2,0 with bc 0,1,2,0.
    stage = STAGE_PARAMETERS_LOADING;
    step();
    load(2, 0); step();
    load(1, 1); step();
    load(2, 2);
    expect_("pd_after3", S_PD, 0);
    step();
    load(0, 0);
    expect_("pd_after4", S_PD, 1);
    expect_("w_slot0", S_W, 2);
    expect_("fg_slot0", S_FG, 0);
    step();
    pv = 0;

    stage = STAGE_IDLE; cs = 1; csel = 1;
    expect_("act_1", S_ACT, 1);
    expect_("w_slot1", S_W, 1);
    expect_("bc_slot1", S_BC, 1);
    step();
    cs = 0;

    // Boundary slot ignores B growth.
    stage = STAGE_GROW; bi = 3;
    expect_("b_only_fg", S_FG, 0);
    expect_("b_only_ib", S_IB, 0);
    step();
    bi = 0; ai = 1;
    expect_("a_ib", S_IB, 1);
    expect_("a_fg", S_FG, 1);
    step();
    ai = 0;

    cs = 1; csel = 0;
    expect_("act_0", S_ACT, 0);
    expect_("fwd_a", S_AOUT, 32'h1234);
    expect_("fwd_b", S_BOUT, 32'h0abc);
    step();
    cs = 0; ai = 1; bi = 3;
    expect_("sat_fg", S_FG, 1);
    step();
    ai = 0; bi = 0;

    stage = STAGE_MEASUREMENT_LOADING;
    expect_("meas_clr", S_FG, 0);
    step();
    stage = STAGE_GROW; ai = 1;
    expect_("half_fg", S_FG, 0);
    step();

    // Increase held through both switch cycles must not count.
    cs = 1; csel = 2;
    expect_("act_2", S_ACT, 2);
    expect_("bc_slot2", S_BC, 2);
    expect_("fg_slot2", S_FG, 0);
    expect_("nofwd_a", S_AOUT, 0);
    expect_("nofwd_b", S_BOUT, 0);
    step();
    csel = 0;
    expect_("back_0", S_ACT, 0);
    expect_("held_fg", S_FG, 0);
    step();
    cs = 0;
    expect_("resume_fg", S_FG, 1);
    step();
    ai = 0;

    // Erasure write together with a switch.
    stage = STAGE_ERASURE_LOADING;
    ev = 1; ein = 1; csel = 3; cs = 1;
    expect_("act_3", S_ACT, 3);
    expect_("er_slot3", S_ER, 1);
    step();
    ev = 0; csel = 0;
    expect_("er_slot0_0", S_ER, 0);
    step();
    cs = 0;
    stage = STAGE_MEASUREMENT_LOADING;
    expect_("meas_clr2", S_FG, 0);
    step();
    stage = STAGE_ERASURE_LOADING; ev = 1; ein = 1; csel = 0;
    expect_("er_slot0", S_ER, 1);
    expect_("er_hold_fg", S_FG, 0);
    step();
    ev = 0; stage = STAGE_GROW;
    expect_("er_grow_fg", S_FG, 1);
    step();

    stage = STAGE_PEELING; ae = 1;
    expect_("peel_err", S_ERR, 1);
    step();
    ae = 0; stage = STAGE_RESULT_VALID; sys = 0;
    expect_("res_err0", S_ERR, 0);
    step();
    sys = 1;
    expect_("res_err1", S_ERR, 1);
    step();
    sys = 0; stage = STAGE_PEELING; be = 1; cs = 1; csel = 1;
    expect_("act_1b", S_ACT, 1);
    step();
    cs = 0;
    expect_("bnd_b_err", S_ERR, 0);
    step();
    be = 0; ae = 1;
    expect_("bnd_a_err", S_ERR, 1);
    step();
    ae = 0;

    // Reset in the middle of a load.
    stage = STAGE_PARAMETERS_LOADING;
    load(1, 0); step();
    load(2, 1); step();
    pv = 0; reset = 1;
    step();
    reset = 0;
    expect_("mid_pd", S_PD, 0);
    expect_("mid_act", S_ACT, 0);
    expect_("mid_w", S_W, 0);
    step();
    load(1, 0); step();
    load(2, 1); step();
    load(0, 0);
    expect_("re_pd3", S_PD, 0);
    step();
    load(2, 0);
    expect_("re_pd4", S_PD, 1);
    expect_("re_w0", S_W, 1);
    step();
    load(0, 2);
    expect_("wrap_pd", S_PD, 1);
    expect_("wrap_w0", S_W, 0);
    expect_("wrap_bc0", S_BC, 2);
    step();

    // Loads and erasures outside their stages are ignored.
    stage = STAGE_IDLE; load(2, 1); ev = 1; ein = 1; csel = 0;
    expect_("ign_w", S_W, 0);
    expect_("ign_bc", S_BC, 2);
    expect_("ign_er", S_ER, 0);
    step();
    pv = 0; ev = 0; cs = 1; csel = 1;
    expect_("re_w1", S_W, 2);
    expect_("re_bc1", S_BC, 1);
    step();
    cs = 0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
